// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and character type
//
// Purpose: character width, oversampling and frame constants shared by the
//          UART receiver, transmitter and receive FIFO.
// Ports:   none (package).
package uart_pkg;

   localparam int UART_DATA_BITS     = 8;
   localparam int UART_TICKS_PER_BIT = 16;
   localparam int UART_BITS_PER_CHAR = 10;

   typedef logic [UART_DATA_BITS-1:0] data_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - simple dual-port RAM for the UART receive FIFO
//
// Purpose: 2**ADDR_BITS x DATA_BITS storage, synchronous write, asynchronous
//          read, kept separate so FPGA flows can map it to distributed RAM.
// Ports:   clk      - system clock
//          wr_en    - write strobe
//          wr_addr  - write address
//          wr_data  - write data
//          rd_addr  - read address
//          rd_data  - read data (combinational from rd_addr)
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [DATA_BITS-1:0] rd_data
);

   logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO behind the UART receiver
//
// Purpose: buffers received characters, exposes the head entry combinationally,
//          and reports full/empty/occupancy/almost-full/sticky-overflow status.
//          Define UART_RX_FIFO_TIMEOUT_EN to add the character-timeout flag.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          bd_tick       - 16x baud tick (timeout feature only)
//          wr_en/wr_data - push strobe and character
//          rd_en/rd_data - pop strobe and head entry
//          empty, full, count, almost_full - occupancy status
//          overflow, overflow_clr - sticky dropped-push flag and its clear
//          rx_timeout    - character timeout (0 when feature is off)
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS     = UART_DATA_BITS,
   parameter int ADDR_BITS     = 4,
   parameter int AF_LEVEL      = 12,
   parameter int TIMEOUT_CHARS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bd_tick,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 empty,
   output logic                 full,
   output logic [ADDR_BITS:0]   count,
   output logic                 almost_full,
   output logic                 overflow,
   input  logic                 overflow_clr,
   output logic                 rx_timeout
);

   localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(2**ADDR_BITS);
   localparam logic [ADDR_BITS:0] AF_C    = (ADDR_BITS+1)'(AF_LEVEL);

   logic [ADDR_BITS-1:0] wr_ptr;
   logic [ADDR_BITS-1:0] rd_ptr;
   logic [ADDR_BITS:0]   count_next;
   logic                 push;
   logic                 pop;
   logic                 drop;

   // A full FIFO still accepts a push when a pop frees the head slot in the
   // same cycle; full implies non-empty, so that pop is always accepted.
   always_comb begin
      pop  = rd_en & ~empty;
      push = wr_en & (~full | pop);
      drop = wr_en & ~push;
      count_next = count;
      if (push & ~pop) begin
         count_next = count + 1'b1;
      end else if (pop & ~push) begin
         count_next = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         empty       <= 1'b1;
         full        <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count       <= count_next;
         empty       <= (count_next == '0);
         full        <= (count_next == DEPTH_C);
         almost_full <= (count_next >= AF_C);
         // A drop in the same cycle as a clear must leave the flag set.
         if (drop) begin
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   uart_fifo_mem #(
      .DATA_BITS (DATA_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam int TIMEOUT_TICKS = TIMEOUT_CHARS * UART_BITS_PER_CHAR * UART_TICKS_PER_BIT;
   localparam int IDLE_W        = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_TICKS);

   logic [IDLE_W-1:0] idle_cnt;
   logic [IDLE_W-1:0] idle_next;

   // Idle time only accumulates while data sits untouched in the FIFO;
   // the counter saturates at the timeout threshold.
   always_comb begin
      idle_next = idle_cnt;
      if (push | pop | empty) begin
         idle_next = '0;
      end else if (bd_tick && (idle_cnt != IDLE_MAX)) begin
         idle_next = idle_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt   <= '0;
         rx_timeout <= 1'b0;
      end else begin
         idle_cnt <= idle_next;
         if (pop) begin
            rx_timeout <= 1'b0;
         end else if (~empty && (idle_next == IDLE_MAX)) begin
            rx_timeout <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = bd_tick | (TIMEOUT_CHARS == 0);
   assign rx_timeout     = 1'b0;
`endif

endmodule
